// File: rtl/cosine_sim_obi_if.sv
// OBI request/response bundle for the cosine-similarity accelerator.
interface cosine_sim_obi_if #(
   parameter int unsigned IdWidth = 1
) ();
   logic               req_i;
   logic               we_i;
   logic [3:0]         be_i;
   logic [31:0]        addr_i;
   logic [31:0]        wdata_i;
   logic [IdWidth-1:0] aid_i;
   logic               gnt_o;
   logic               rvalid_o;
   logic [31:0]        rdata_o;
   logic               err_o;
   logic [IdWidth-1:0] rid_o;

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i, aid_i,
      input  gnt_o, rvalid_o, rdata_o, err_o, rid_o
   );

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i, aid_i,
      output gnt_o, rvalid_o, rdata_o, err_o, rid_o
   );
endinterface

// File: rtl/cosine_sim_obi.sv
// Cosine-similarity MAC accelerator as an OBI subordinate: software loads int8
// vectors A/B, starts the engine, and reads dot(A,B), |A|^2 and |B|^2.
module cosine_sim_obi #(
   parameter int unsigned MaxElems = 64,
   parameter int unsigned IdWidth  = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   cosine_sim_obi_if.slave obi
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [6:0] MAX_N   = 7'(MaxElems);

   // Words 0..15 hold VEC_A, words 16..31 hold VEC_B.
   logic [31:0]        vec_q [32];
   logic [31:0]        vec_d [32];
   logic [6:0]         len_q, len_d, n_q, n_d, idx_q, idx_d;
   logic [1:0]         state_q, state_d;
   logic [31:0]        dot_acc_q, dot_acc_d, na_acc_q, na_acc_d, nb_acc_q, nb_acc_d;
   logic [31:0]        dot_q, dot_d, norm_a_q, norm_a_d, norm_b_q, norm_b_d;
   logic               rvalid_q, rvalid_d, err_q, err_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [IdWidth-1:0] rid_q, rid_d;

   logic [5:0]         off_s;
   logic               busy_s, done_s, start_s, clr_s, launch_s;
   logic [6:0]         len_eff_s;
   logic [31:0]        a_word_s, b_word_s;
   logic signed [7:0]  a_s, b_s;
   logic signed [15:0] ab_s, aa_s, bb_s;
   logic               unused_s;

   assign unused_s = ^{obi.addr_i[31:8], obi.addr_i[1:0]};

   // Bus decode, register writes and response formation.
   always_comb begin
      off_s   = obi.addr_i[7:2];
      busy_s  = (state_q == ST_RUN);
      done_s  = (state_q == ST_DONE);
      vec_d   = vec_q;
      len_d   = len_q;
      start_s = 1'b0;
      clr_s   = 1'b0;
      rdata_d = 32'd0;
      err_d   = 1'b0;
      rvalid_d = obi.req_i;
      rid_d   = obi.req_i ? obi.aid_i : '0;
      if (obi.req_i) begin
         if (off_s[5] == 1'b0) begin
            if (!obi.we_i) begin
               rdata_d = vec_q[off_s[4:0]];
            end else if (busy_s) begin
               err_d = 1'b1;
            end else begin
               for (int b = 0; b < 4; b++) begin
                  if (obi.be_i[b]) begin
                     vec_d[off_s[4:0]][8*b +: 8] = obi.wdata_i[8*b +: 8];
                  end else begin
                     vec_d[off_s[4:0]][8*b +: 8] = vec_q[off_s[4:0]][8*b +: 8];
                  end
               end
            end
         end else begin
            case (off_s)
               6'd32: begin
                  if (obi.we_i && obi.be_i[0]) begin
                     start_s = obi.wdata_i[0];
                     clr_s   = obi.wdata_i[1];
                  end else begin
                     rdata_d = 32'd0;
                  end
               end
               6'd33: begin
                  if (obi.we_i) err_d = 1'b1;
                  else          rdata_d = {30'd0, done_s, busy_s};
               end
               6'd34: begin
                  if (!obi.we_i)     rdata_d = {25'd0, len_q};
                  else if (busy_s)   err_d = 1'b1;
                  else if (obi.be_i[0]) len_d = obi.wdata_i[6:0];
                  else               len_d = len_q;
               end
               6'd35: begin
                  if (obi.we_i) err_d = 1'b1;
                  else          rdata_d = dot_q;
               end
               6'd36: begin
                  if (obi.we_i) err_d = 1'b1;
                  else          rdata_d = norm_a_q;
               end
               6'd37: begin
                  if (obi.we_i) err_d = 1'b1;
                  else          rdata_d = norm_b_q;
               end
               default: err_d = 1'b1;
            endcase
         end
      end else begin
         err_d = 1'b0;
      end
   end

   // MAC engine: one element per cycle, results captured when the last one lands.
   always_comb begin
      len_eff_s = (len_q > MAX_N) ? MAX_N : len_q;
      launch_s  = start_s && (state_q != ST_RUN);
      a_word_s  = vec_q[{1'b0, idx_q[5:2]}];
      b_word_s  = vec_q[{1'b1, idx_q[5:2]}];
      a_s       = a_word_s[{idx_q[1:0], 3'b000} +: 8];
      b_s       = b_word_s[{idx_q[1:0], 3'b000} +: 8];
      ab_s      = a_s * b_s;
      aa_s      = a_s * a_s;
      bb_s      = b_s * b_s;
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      dot_acc_d = dot_acc_q;
      na_acc_d  = na_acc_q;
      nb_acc_d  = nb_acc_q;
      dot_d     = dot_q;
      norm_a_d  = norm_a_q;
      norm_b_d  = norm_b_q;
      if (launch_s) begin
         dot_acc_d = 32'd0;
         na_acc_d  = 32'd0;
         nb_acc_d  = 32'd0;
         idx_d     = 7'd0;
         n_d       = len_eff_s;
         if (len_eff_s == 7'd0) begin
            state_d  = ST_DONE;
            dot_d    = 32'd0;
            norm_a_d = 32'd0;
            norm_b_d = 32'd0;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               dot_acc_d = dot_acc_q + {{16{ab_s[15]}}, ab_s};
               na_acc_d  = na_acc_q + {16'd0, aa_s};
               nb_acc_d  = nb_acc_q + {16'd0, bb_s};
               idx_d     = idx_q + 7'd1;
               if (idx_q == (n_q - 7'd1)) begin
                  state_d  = ST_DONE;
                  dot_d    = dot_acc_d;
                  norm_a_d = na_acc_d;
                  norm_b_d = nb_acc_d;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (clr_s) state_d = ST_IDLE;
               else       state_d = ST_DONE;
            end
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and response registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) vec_q[i] <= 32'd0;
         len_q     <= 7'd0;
         n_q       <= 7'd0;
         idx_q     <= 7'd0;
         state_q   <= ST_IDLE;
         dot_acc_q <= 32'd0;
         na_acc_q  <= 32'd0;
         nb_acc_q  <= 32'd0;
         dot_q     <= 32'd0;
         norm_a_q  <= 32'd0;
         norm_b_q  <= 32'd0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 32'd0;
         rid_q     <= '0;
      end else begin
         vec_q     <= vec_d;
         len_q     <= len_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         state_q   <= state_d;
         dot_acc_q <= dot_acc_d;
         na_acc_q  <= na_acc_d;
         nb_acc_q  <= nb_acc_d;
         dot_q     <= dot_d;
         norm_a_q  <= norm_a_d;
         norm_b_q  <= norm_b_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         rid_q     <= rid_d;
      end
   end

   assign obi.gnt_o    = obi.req_i;
   assign obi.rvalid_o = rvalid_q;
   assign obi.rdata_o  = rdata_q;
   assign obi.err_o    = err_q;
   assign obi.rid_o    = rid_q;
endmodule
